// File: rtl/write_back_quant_pkg.sv
// Shared definitions for the write-back quantizer: state encoding, default sizes and
// a saturating counter helper.
package write_back_quant_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam int unsigned ARRAY_SIZE_DEFAULT = 32;
    localparam int unsigned IN_WIDTH_DEFAULT   = 20;
    localparam int unsigned OUT_WIDTH_DEFAULT  = 8;
    localparam int unsigned ROWS_DEFAULT       = 64;

    typedef enum logic [1:0] {
        StIdle   = IDLE,
        StActive = ACTIVE,
        StDrain  = DRAIN,
        StDone   = DONE
    } wb_state_e;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/quant_lane.sv
// One accumulator lane: round-half-up, arithmetic right shift, saturate to OUT_WIDTH.
module quant_lane
    import write_back_quant_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = IN_WIDTH_DEFAULT,
    parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEFAULT
) (
    input  logic [IN_WIDTH-1:0]  din,
    input  logic [4:0]           shift,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 sat
);

    localparam logic signed [IN_WIDTH:0] MAX_V = (IN_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [IN_WIDTH:0] MIN_V = (IN_WIDTH+1)'(-(1 << (OUT_WIDTH-1)));

    logic signed [IN_WIDTH:0] ext;
    logic signed [IN_WIDTH:0] rnd;
    logic signed [IN_WIDTH:0] sum;
    logic signed [IN_WIDTH:0] shr;

    always_comb begin
        ext = {din[IN_WIDTH-1], din};
        rnd = '0;
        if (shift != 5'd0 && 32'(shift) <= IN_WIDTH) begin
            rnd = (IN_WIDTH+1)'(1) << (shift - 5'd1);
        end
        sum = ext + rnd;
        shr = sum >>> shift;
        // Shifting past the full input width always rounds to zero.
        if (32'(shift) > IN_WIDTH) begin
            shr = '0;
        end

        sat  = 1'b0;
        dout = shr[OUT_WIDTH-1:0];
        if (shr > MAX_V) begin
            dout = MAX_V[OUT_WIDTH-1:0];
            sat  = 1'b1;
        end else if (shr < MIN_V) begin
            dout = MIN_V[OUT_WIDTH-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/write_back_quant.sv
// Two-stage write-back path: captures systolic rows, quantizes every lane and writes the
// packed result to SRAM bank A or B, with sequence checking and a saturation counter.
module write_back_quant
    import write_back_quant_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE = ARRAY_SIZE_DEFAULT,
    parameter int unsigned IN_WIDTH   = IN_WIDTH_DEFAULT,
    parameter int unsigned OUT_WIDTH  = OUT_WIDTH_DEFAULT,
    parameter int unsigned ROWS       = ROWS_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wb_start,
    input  logic                            in_valid,
    input  logic [5:0]                      in_index,
    input  logic [1:0]                      in_set,
    input  logic [ARRAY_SIZE*IN_WIDTH-1:0]  in_data,
    input  logic [4:0]                      shift,
    output logic                            sram_wen_a,
    output logic                            sram_wen_b,
    output logic [5:0]                      sram_waddr,
    output logic [ARRAY_SIZE*OUT_WIDTH-1:0] sram_wdata,
    output logic [15:0]                     sat_count,
    output logic                            err_seq,
    output logic                            wb_busy,
    output logic                            wb_done
);

    localparam logic [5:0] LAST_IDX = 6'(ROWS - 1);

    wb_state_e  state;
    logic       drain_cnt;
    logic [6:0] exp_cnt;
    logic       accept;
    logic       last_row;
    logic       seq_bad;

    logic                           s1_valid;
    logic [5:0]                     s1_index;
    logic                           s1_bank;
    logic [ARRAY_SIZE*IN_WIDTH-1:0] s1_data;
    logic                           s1_write;
    logic                           wen_a_q;
    logic                           wen_b_q;

    logic [ARRAY_SIZE*OUT_WIDTH-1:0] q_row;
    logic [ARRAY_SIZE-1:0]           q_sat;
    logic [15:0]                     sat_sum;

    // A start pulse arms the block in the same cycle, so a row arriving with it is row 0.
    assign accept   = in_valid && (state == StActive || wb_start);
    assign last_row = (in_index == LAST_IDX) && (in_set == 2'd1);
    assign seq_bad  = {in_set[0], in_index} != exp_cnt;
    assign s1_write = s1_valid && !wb_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            drain_cnt <= 1'b0;
            exp_cnt   <= 7'd0;
            err_seq   <= 1'b0;
            wb_busy   <= 1'b0;
            wb_done   <= 1'b0;
        end else begin
            wb_done <= 1'b0;
            if (wb_start) begin
                exp_cnt   <= accept ? 7'd1 : 7'd0;
                err_seq   <= accept && seq_bad;
                drain_cnt <= 1'b0;
                state     <= (accept && last_row) ? StDrain : StActive;
                wb_busy   <= 1'b1;
            end else begin
                unique case (state)
                    StIdle: ;
                    StActive: begin
                        if (accept) begin
                            exp_cnt <= exp_cnt + 7'd1;
                            if (seq_bad) begin
                                err_seq <= 1'b1;
                            end
                            if (last_row) begin
                                state     <= StDrain;
                                drain_cnt <= 1'b0;
                            end
                        end
                    end
                    StDrain: begin
                        drain_cnt <= 1'b1;
                        if (drain_cnt) begin
                            state <= StDone;
                        end
                    end
                    StDone: begin
                        state   <= StIdle;
                        wb_done <= 1'b1;
                        wb_busy <= 1'b0;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_lane
        quant_lane #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_lane (
            .din   (s1_data[k*IN_WIDTH +: IN_WIDTH]),
            .shift (shift),
            .dout  (q_row[k*OUT_WIDTH +: OUT_WIDTH]),
            .sat   (q_sat[k])
        );
    end

    always_comb begin
        sat_sum = '0;
        for (int k = 0; k < ARRAY_SIZE; k++) begin
            sat_sum = sat_sum + 16'(q_sat[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_index   <= 6'd0;
            s1_bank    <= 1'b0;
            s1_data    <= '0;
            wen_a_q    <= 1'b0;
            wen_b_q    <= 1'b0;
            sram_waddr <= 6'd0;
            sram_wdata <= '0;
            sat_count  <= 16'd0;
        end else begin
            s1_valid   <= accept;
            s1_index   <= in_index;
            s1_bank    <= in_set[0];
            s1_data    <= in_data;
            sram_waddr <= s1_index;
            wen_a_q    <= s1_write && !s1_bank;
            wen_b_q    <= s1_write && s1_bank;
            if (s1_write) begin
                sram_wdata <= q_row;
            end
            if (wb_start) begin
                sat_count <= 16'd0;
            end else if (s1_valid) begin
                sat_count <= sat_add16(sat_count, sat_sum);
            end
        end
    end

    // A restart also kills the write already sitting in the output register.
    assign sram_wen_a = wen_a_q && !wb_start;
    assign sram_wen_b = wen_b_q && !wb_start;

endmodule

// File: doc/write_back_quant.md
WRITE_BACK_QUANT -- requirements
Module: write_back_quant

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 32, the number of output lanes per row.
REQ-002 SHALL have parameter IN_WIDTH, default 20, the signed width of each accumulator lane.
REQ-003 SHALL have parameter OUT_WIDTH, default 8, the signed width of each quantized lane.
REQ-004 SHALL have parameter ROWS, default 64, the number of rows per data set (index range 0..63).
REQ-005 Ports SHALL be as follows; clock and reset use one clock, with asynchronous active-high reset.
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  asynchronous active-high reset.
- wb_start  in  1  one-cycle pulse that arms the block and clears counters and flags.
- in_valid  in  1  row valid; driven by the controller's sram_write_enable.
- in_index  in  6  row index; driven by the controller's matrix_index.
- in_set  in  2  data set; driven by the controller's data_set.
- in_data  in  ARRAY_SIZE*IN_WIDTH  systolic row; lane k occupies bits [k*IN_WIDTH +: IN_WIDTH].
- shift  in  5  right-shift amount, static while busy.
- sram_wen_a  out  1  write enable for bank A (set 0).
- sram_wen_b  out  1  write enable for bank B (set 1).
- sram_waddr  out  6  write address.
- sram_wdata  out  ARRAY_SIZE*OUT_WIDTH  packed quantized row.
- sat_count  out  16  count of saturated lanes.
- err_seq  out  1  sticky flag for an out-of-order row.
- wb_busy  out  1  high in any state other than IDLE.
- wb_done  out  1  one-cycle completion pulse.

Function
REQ-006 SHALL be a two-stage pipeline:
- S1 registers in_valid, in_index, in_set and in_data.
- S2 registers the quantized row, the address and the bank enable.
- Latency from in_valid to sram_wen_* SHALL be exactly 2 cycles; throughput SHALL be one row per cycle.
REQ-007 Quantization per lane SHALL be:
- When shift>0, add 2^(shift-1), then arithmetic right shift by shift.
- Saturate the result to the range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- When shift=0, no rounding term is added.
- The rounding addition SHALL be computed one bit wider than IN_WIDTH so it cannot overflow.
REQ-008 Bank select SHALL be in_set[0]: value 0 drives sram_wen_a, value 1 drives sram_wen_b; sram_wen_a and sram_wen_b SHALL never be high in the same cycle.
REQ-009 sram_waddr SHALL equal in_index delayed by 2 cycles; sram_wdata SHALL hold its last value when no write occurs.
REQ-010 State machine states SHALL be IDLE, ACTIVE, DRAIN and DONE:
- IDLE goes to ACTIVE on wb_start.
- ACTIVE goes to DRAIN when an accepted row has in_index=63 and in_set=1.
- DRAIN waits 2 cycles, then goes to DONE.
- DONE asserts wb_done for one cycle, then returns to IDLE.
REQ-011 Rows SHALL be accepted only in ACTIVE; in_valid in IDLE, DRAIN or DONE SHALL be ignored and produce no write.
REQ-012 An expected-row counter of 7 bits, reset to 0 on wb_start, SHALL increment on every accepted row; {in_set[0], in_index} different from the counter SHALL set err_seq, which stays set until wb_start or rst.
REQ-013 sat_count SHALL add the number of saturated lanes in each S2 row and SHALL saturate at 16'hFFFF.
REQ-014 wb_start while in ACTIVE, DRAIN or DONE SHALL do all of the following:
- Restart into ACTIVE.
- Clear the counters and err_seq.
- Squash in-flight pipeline writes, so no sram_wen fires for rows accepted before the restart.
REQ-015 wb_start and in_valid in the same cycle from IDLE SHALL accept that row as row 0.

Reset
REQ-016 rst SHALL force the following reset values:
- state=IDLE
- pipeline valids=0, sram_wen_a=0, sram_wen_b=0
- sram_waddr=0, sram_wdata=0
- sat_count=0, err_seq=0
- wb_busy=0, wb_done=0
- expected-row counter=0
REQ-017 rst asserted mid-operation SHALL cancel all pending writes immediately, with no write pulses after reset assertion.

Structure
REQ-018 A shared package SHALL hold the state encoding localparams (IDLE=0, ACTIVE=1, DRAIN=2, DONE=3) and the defaults for ROWS, IN_WIDTH and OUT_WIDTH, reused by the controller and the array.
REQ-019 The per-lane round/shift/saturate function SHALL be one sub-module, quant_lane, that outputs the OUT_WIDTH value and a sat flag, instantiated ARRAY_SIZE times by a generate loop.

Verification
REQ-020 Sequential run: wb_start, then 128 rows (set 0 index 0..63, then set 1 index 0..63) with lane value 256 and shift=4 -> every lane reads 16, 64 writes on A followed by 64 on B with addresses 0..63, wb_done asserts 4 cycles after the last row, sat_count=0, err_seq=0.
REQ-021 Rounding and saturation with shift=2: inputs 5→1, 6→2, -6→-1, 1000→127, -1000→-128 -> sat_count increments by 2 per such row.
REQ-022 Out-of-order row: index 5 sent where index 4 is expected -> err_seq=1 and the write still occurs at address 5; the next wb_start clears err_seq.
REQ-023 Restart: wb_start one cycle after the row with index 10 -> no writes for rows 9 and 10 appear, the counter restarts at 0, and wb_busy stays 1.
REQ-024 Reset mid-run: rst asserted at row 30 -> the outputs take the REQ-016 values in the same cycle, no sram_wen pulses occur afterwards, and the block returns to IDLE.
REQ-025 Idle input: in_valid pulses in IDLE and DRAIN -> no sram_wen, and sat_count is unchanged.
